wb_scoreboard: RTL and testbench
================================

Name: wb_scoreboard

Overview:
- Parametrised successor to the pipeline's register-forwarding and decode-pause logic.
- Tracks pending destination-register writes from issue until writeback, using per-register counters.
- Raises a decode stall on RAW hazards.
- Arbitrates NUM_WB writeback requesters (EXE, MEM, future units) onto the single register-file write port with the existing req/resp handshake.

Parameters:
- NUM_WB, 2, number of writeback requesters; index 0 is highest priority in fixed mode.
- NUM_REGS, 32, architectural register count; register 0 is hard-wired zero.
- ADDR_W, 5, register address width; must be at least clog2(NUM_REGS).
- DATA_WIDTH, 32, register data width.
- MAX_PEND, 3, maximum outstanding writes per register; counter width is clog2(MAX_PEND+1).
- ARB_RR, 0, arbitration mode: 0 = fixed priority, 1 = round-robin.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- issue_valid  in  1  decode issues an instruction that writes issue_rd
- issue_rd  in  ADDR_W  destination of the issued instruction
- issue_ready  out  1  counter for issue_rd is not saturated
- rs1_addr  in  ADDR_W  decode source 1
- rs2_addr  in  ADDR_W  decode source 2
- stall  out  1  RAW hazard on rs1 or rs2
- flush  in  1  discard all pending state (branch taken)
- wb_req  in  NUM_WB  writeback request per requester; held until resp
- wb_addr  in  NUM_WB*ADDR_W  packed destination addresses; requester i at bits [i*ADDR_W +: ADDR_W]
- wb_data  in  NUM_WB*DATA_WIDTH  packed write data
- wb_resp  out  NUM_WB  one-hot grant, same cycle as the write
- rf_we  out  1  register-file write enable
- rf_waddr  out  ADDR_W  register-file write address
- rf_wdata  out  DATA_WIDTH  register-file write data
- pending_any  out  1  at least one counter is non-zero

Behaviour:
- State:
  - pend[r]: NUM_REGS counters; pend[0] is never written and reads as 0.
  - rr_ptr: clog2(NUM_WB)-bit round-robin pointer.
- Reset (async, rst=1):
  - All pend = 0, rr_ptr = 0.
  - Outputs: stall=0, issue_ready=1, wb_resp=0, rf_we=0, rf_waddr=0, rf_wdata=0, pending_any=0.
  - Reset asserted mid-operation drops all pending state immediately; no write occurs in that cycle.
- Arbitration (combinational):
  - Fixed mode: grant the lowest-index asserted wb_req.
  - Round-robin mode: grant the first asserted request at or after rr_ptr, wrapping from NUM_WB-1 to 0.
  - rr_ptr <= granted index + 1 (mod NUM_WB) on every grant; unchanged when there is no grant.
  - Grant gives rf_we=1, rf_waddr/rf_wdata from the winner, and wb_resp[winner]=1 in the same cycle.
  - No request: rf_we=0, rf_waddr=0, rf_wdata=0.
  - Requester protocol: wb_req stays high with stable addr/data until its resp cycle, then may drop or present the next write.
  - wb_addr=0: the write is forwarded to the register file (which ignores x0); no counter change.
- Counters (update at posedge):
  - inc = issue_valid & issue_ready & (issue_rd != 0).
  - dec = grant & (rf_waddr != 0) & (pend[rf_waddr] != 0); decrement saturates at 0.
  - Same register incremented and decremented in one cycle: count unchanged.
  - issue_ready = (pend[issue_rd] < MAX_PEND); issue_rd=0 always gives ready.
  - flush=1: all pend <= 0 at the next edge, overriding inc and dec. Later writebacks still complete and their decrement saturates.
- Hazard (combinational): stall = (rs1_addr != 0 & pend[rs1_addr] != 0) | (rs2_addr != 0 & pend[rs2_addr] != 0). No bypass, so a stall persists through the retire cycle and clears the cycle after.
- pending_any: OR of all counters, combinational from state.

Optional Feature:
- Macro: WB_SCOREBOARD_BYPASS_EN.
- With the macro:
  - Added outputs: rs1_byp_valid, rs2_byp_valid (1 bit each) and rs1_byp_data, rs2_byp_data (DATA_WIDTH each).
  - rsX_byp_valid=1 when the grant this cycle targets rsX_addr (non-zero) and pend[rsX_addr]==1.
  - rsX_byp_data = rf_wdata in that case.
  - stall ignores a source that is bypassed this cycle, so decode proceeds one cycle earlier.
  - All bypass outputs reset to 0.
- Without the macro: these ports are absent and behaviour is exactly as above.

Test Plan:
- Issue rd=5, then hold rs1=5 -> stall=1 until the cycle after wb_req[0] with addr=5, data=0xDEADBEEF is granted; rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, wb_resp=2'b01 in that grant cycle; stall=0 the cycle after.
- wb_req=2'b11 held 4 cycles, each requester re-requesting after its grant:
  - ARB_RR=0 -> every grant to requester 0.
  - ARB_RR=1 -> wb_resp sequence 01,10,01,10.
- Issue rd=7 four times with MAX_PEND=3 and no writeback -> issue_ready=0 after the third; the fourth issue is ignored; three writebacks to 7 -> pend[7]=0, pending_any=0.
- Issue rd=3 and grant a writeback to 3 in the same cycle while pend[3]=1 -> pend[3] stays 1 and stall on rs2=3 remains.
- pend[4]=2, assert flush -> pending_any=0 next cycle; a later writeback to 4 writes the register file and the counter stays 0.
- Issue rd=0 or rs1=0 -> no counter change, stall=0; assert rst mid-stall -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: tracks outstanding destination-register writes from issue to
// writeback with per-register counters. It stalls decode on RAW hazards and
// arbitrates NUM_WB writeback requesters onto the single register-file write port.
// Optional feature macro: WB_SCOREBOARD_BYPASS_EN adds same-cycle writeback
// bypass outputs and lets decode proceed during the retire cycle.
module wb_scoreboard #(
   parameter int NUM_WB     = 2,
   parameter int NUM_REGS   = 32,
   parameter int ADDR_W     = 5,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_PEND   = 3,
   parameter int ARB_RR     = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         issue_valid,
   input  logic [ADDR_W-1:0]            issue_rd,
   output logic                         issue_ready,
   input  logic [ADDR_W-1:0]            rs1_addr,
   input  logic [ADDR_W-1:0]            rs2_addr,
   output logic                         stall,
   input  logic                         flush,
   input  logic [NUM_WB-1:0]            wb_req,
   input  logic [NUM_WB*ADDR_W-1:0]     wb_addr,
   input  logic [NUM_WB*DATA_WIDTH-1:0] wb_data,
   output logic [NUM_WB-1:0]            wb_resp,
   output logic                         rf_we,
   output logic [ADDR_W-1:0]            rf_waddr,
   output logic [DATA_WIDTH-1:0]        rf_wdata,
`ifdef WB_SCOREBOARD_BYPASS_EN
   output logic                         rs1_byp_valid,
   output logic                         rs2_byp_valid,
   output logic [DATA_WIDTH-1:0]        rs1_byp_data,
   output logic [DATA_WIDTH-1:0]        rs2_byp_data,
`endif
   output logic                         pending_any
);

   localparam int CNT_W = $clog2(MAX_PEND + 1);
   localparam int PTR_W = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PEND);

   // Register 0 is hard-wired zero, so it has no counter at all.
   logic [CNT_W-1:0]  r_pend [1:NUM_REGS-1];
   logic [PTR_W-1:0]  r_rr_ptr;

   logic              w_grant;
   logic [PTR_W-1:0]  w_gidx;
   logic [PTR_W-1:0]  w_ptr_nxt;
   logic [ADDR_W-1:0] w_gaddr;
   logic [CNT_W-1:0]  w_cnt_rd;
   logic [CNT_W-1:0]  w_cnt_rs1;
   logic [CNT_W-1:0]  w_cnt_rs2;
   logic [CNT_W-1:0]  w_cnt_wb;
   logic              w_any;
   logic              w_inc;
   logic              w_dec;
   logic              w_haz1;
   logic              w_haz2;

   // Pick the winning writeback requester (fixed priority or round-robin from r_rr_ptr).
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      w_grant = 1'b0;
      w_gidx  = '0;
      if (ARB_RR == 0) begin
         for (int i = NUM_WB - 1; i >= 0; i--) begin
            if (wb_req[i]) begin
               w_grant = 1'b1;
               w_gidx  = PTR_W'(i);
            end
         end
      end else begin
         for (int k = NUM_WB - 1; k >= 0; k--) begin
            if (wb_req[(int'(r_rr_ptr) + k) % NUM_WB]) begin
               w_grant = 1'b1;
               w_gidx  = PTR_W'((int'(r_rr_ptr) + k) % NUM_WB);
            end
         end
      end
      // Reset suppresses the write in the cycle it is asserted.
      if (rst) w_grant = 1'b0;
   end

   assign w_gaddr   = wb_addr[w_gidx*ADDR_W +: ADDR_W];
   assign w_ptr_nxt = (w_gidx == PTR_W'(NUM_WB - 1)) ? '0 : w_gidx + 1'b1;
   assign rf_we     = w_grant;
   assign rf_waddr  = w_grant ? w_gaddr : '0;
   assign rf_wdata  = w_grant ? wb_data[w_gidx*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign wb_resp   = w_grant ? (NUM_WB'(1) << w_gidx) : '0;

   // Look up the counters addressed by issue, both sources and the writeback; x0 reads zero.
   always_comb begin
      w_cnt_rd  = '0;
      w_cnt_rs1 = '0;
      w_cnt_rs2 = '0;
      w_cnt_wb  = '0;
      w_any     = 1'b0;
      for (int r = 1; r < NUM_REGS; r++) begin
         if (issue_rd == ADDR_W'(r)) w_cnt_rd  = r_pend[r];
         if (rs1_addr == ADDR_W'(r)) w_cnt_rs1 = r_pend[r];
         if (rs2_addr == ADDR_W'(r)) w_cnt_rs2 = r_pend[r];
         if (rf_waddr == ADDR_W'(r)) w_cnt_wb  = r_pend[r];
         if (r_pend[r] != '0)        w_any     = 1'b1;
      end
   end

   assign issue_ready = (issue_rd == '0) || (w_cnt_rd < MAX_CNT);
   assign pending_any = w_any;
   assign w_inc       = issue_valid && issue_ready && (issue_rd != '0);
   assign w_dec       = w_grant && (rf_waddr != '0) && (w_cnt_wb != '0);
   assign w_haz1      = (rs1_addr != '0) && (w_cnt_rs1 != '0);
   assign w_haz2      = (rs2_addr != '0) && (w_cnt_rs2 != '0);

`ifdef WB_SCOREBOARD_BYPASS_EN
   // Forward the retiring value when it is the last outstanding write to a source.
   always_comb begin
      rs1_byp_valid = rf_we && (rs1_addr != '0) && (rf_waddr == rs1_addr) && (w_cnt_rs1 == CNT_W'(1));
      rs2_byp_valid = rf_we && (rs2_addr != '0) && (rf_waddr == rs2_addr) && (w_cnt_rs2 == CNT_W'(1));
      rs1_byp_data  = rs1_byp_valid ? rf_wdata : '0;
      rs2_byp_data  = rs2_byp_valid ? rf_wdata : '0;
      stall         = (w_haz1 && !rs1_byp_valid) || (w_haz2 && !rs2_byp_valid);
   end
`else
   assign stall = w_haz1 || w_haz2;
`endif

   // Advance the round-robin pointer past each winner and update the pending counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rr_ptr <= '0;
         // NOTE: the counters are state that must read zero after reset, so this array is reset (unlike a data RAM).
         for (int r = 1; r < NUM_REGS; r++) r_pend[r] <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         if (w_grant) r_rr_ptr <= w_ptr_nxt;
         for (int r = 1; r < NUM_REGS; r++) begin
            if (flush) begin
               r_pend[r] <= '0;
            end else if (w_inc && (issue_rd == ADDR_W'(r)) &&
                         !(w_dec && (rf_waddr == ADDR_W'(r)))) begin
               r_pend[r] <= r_pend[r] + 1'b1;
            end else if (w_dec && (rf_waddr == ADDR_W'(r)) &&
                         !(w_inc && (issue_rd == ADDR_W'(r)))) begin
               r_pend[r] <= r_pend[r] - 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_wb_scoreboard.sv
// Self-checking bench for wb_scoreboard: directed scenarios plus a randomized
// run compared against a counter-array reference model. A second instance in
// round-robin mode shares all stimulus and is checked for its grant order.
module tb_wb_scoreboard;

   localparam int NWB = 2;
   localparam int AW  = 5;
   localparam int DW  = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              issue_valid;
   logic [AW-1:0]     issue_rd;
   logic [AW-1:0]     rs1_addr;
   logic [AW-1:0]     rs2_addr;
   logic              flush;
   logic [NWB-1:0]    wb_req;
   logic [NWB*AW-1:0] wb_addr;
   logic [NWB*DW-1:0] wb_data;

   logic              issue_ready, stall, rf_we, pending_any;
   logic [NWB-1:0]    wb_resp;
   logic [AW-1:0]     rf_waddr;
   logic [DW-1:0]     rf_wdata;

   logic              rr_issue_ready, rr_stall, rr_rf_we, rr_pending_any;
   logic [NWB-1:0]    rr_wb_resp;
   logic [AW-1:0]     rr_rf_waddr;
   logic [DW-1:0]     rr_rf_wdata;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   wb_scoreboard #(.NUM_WB(NWB), .ARB_RR(0)) dut (
      .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rd(issue_rd),
      .issue_ready(issue_ready), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .stall(stall), .flush(flush), .wb_req(wb_req), .wb_addr(wb_addr),
      .wb_data(wb_data), .wb_resp(wb_resp), .rf_we(rf_we), .rf_waddr(rf_waddr),
      .rf_wdata(rf_wdata), .pending_any(pending_any)
   );

   wb_scoreboard #(.NUM_WB(NWB), .ARB_RR(1)) dut_rr (
      .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rd(issue_rd),
      .issue_ready(rr_issue_ready), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .stall(rr_stall), .flush(flush), .wb_req(wb_req), .wb_addr(wb_addr),
      .wb_data(wb_data), .wb_resp(rr_wb_resp), .rf_we(rr_rf_we), .rf_waddr(rr_rf_waddr),
      .rf_wdata(rr_rf_wdata), .pending_any(rr_pending_any)
   );

   task automatic idle();
      issue_valid = 1'b0; issue_rd = '0; rs1_addr = '0; rs2_addr = '0;
      flush = 1'b0; wb_req = '0; wb_addr = '0; wb_data = '0;
   endtask

   // Let one rising edge pass and return at the following falling edge.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      cyc();
      rst = 1'b0;
   endtask

   task automatic set_wb(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      wb_req[i] = 1'b1;
      wb_addr[i*AW +: AW] = a;
      wb_data[i*DW +: DW] = d;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      set_wb(0, 5'd3, 32'h1234_5678);
      set_wb(1, 5'd4, 32'h9abc_def0);
      issue_valid = 1'b1; issue_rd = 5'd3; rs1_addr = 5'd3;
      @(negedge clk); #1;
      n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
      n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", issue_ready); end
      n_tests++; if (wb_resp !== 2'b00) begin n_fail++; $display("FAIL reset_resp: got %b want 00", wb_resp); end
      n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", rf_we); end
      n_tests++; if (rf_waddr !== 5'd0) begin n_fail++; $display("FAIL reset_waddr: got %0d want 0", rf_waddr); end
      n_tests++; if (rf_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", rf_wdata); end
      n_tests++; if (pending_any !== 1'b0) begin n_fail++; $display("FAIL reset_any: got %b want 0", pending_any); end
      @(negedge clk);
      idle();
      rst = 1'b0;
      #1;
      n_tests++; if (pending_any !== 1'b0) begin n_fail++; $display("FAIL reset_issue_ignored: got %b want 0", pending_any); end
   endtask

   task automatic test_raw();
      do_reset();
      issue_valid = 1'b1; issue_rd = 5'd5;
      cyc();
      issue_valid = 1'b0; rs1_addr = 5'd5; #1;
      n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall0: got %b want 1", stall); end
      cyc(); #1;
      n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall1: got %b want 1", stall); end
      set_wb(0, 5'd5, 32'hDEAD_BEEF); #1;
      n_tests++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL raw_we: got %b want 1", rf_we); end
      n_tests++; if (rf_waddr !== 5'd5) begin n_fail++; $display("FAIL raw_waddr: got %0d want 5", rf_waddr); end
      n_tests++; if (rf_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL raw_wdata: got %h want deadbeef", rf_wdata); end
      n_tests++; if (wb_resp !== 2'b01) begin n_fail++; $display("FAIL raw_resp: got %b want 01", wb_resp); end
      n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall_retire: got %b want 1", stall); end
      cyc();
      wb_req = '0; #1;
      n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL raw_stall_clear: got %b want 0", stall); end
      n_tests++; if (pending_any !== 1'b0) begin n_fail++; $display("FAIL raw_any: got %b want 0", pending_any); end
      n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL raw_we_idle: got %b want 0", rf_we); end
   endtask

   task automatic test_arbitration();
      logic [1:0]  exp_rr;
      logic [31:0] exp_rr_data;
      do_reset();
      set_wb(0, 5'd1, 32'hAAAA_0000);
      set_wb(1, 5'd2, 32'hBBBB_1111);
      for (int c = 0; c < 4; c++) begin
         exp_rr      = (c % 2 == 0) ? 2'b01 : 2'b10;
         exp_rr_data = (c % 2 == 0) ? 32'hAAAA_0000 : 32'hBBBB_1111;
         #1;
         n_tests++; if (wb_resp !== 2'b01) begin n_fail++; $display("FAIL arb_fixed[%0d]: got %b want 01", c, wb_resp); end
         n_tests++; if (rr_wb_resp !== exp_rr) begin n_fail++; $display("FAIL arb_rr[%0d]: got %b want %b", c, rr_wb_resp, exp_rr); end
         n_tests++; if (rr_rf_wdata !== exp_rr_data) begin n_fail++; $display("FAIL arb_rr_data[%0d]: got %h want %h", c, rr_rf_wdata, exp_rr_data); end
         cyc();
      end
      idle();
   endtask

   task automatic test_saturate();
      do_reset();
      for (int k = 0; k < 4; k++) begin
         issue_valid = 1'b1; issue_rd = 5'd7; #1;
         n_tests++; if (issue_ready !== (k < 3)) begin n_fail++; $display("FAIL sat_ready[%0d]: got %b want %b", k, issue_ready, (k < 3)); end
         cyc();
      end
      issue_valid = 1'b0; #1;
      n_tests++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL sat_ready_hold: got %b want 0", issue_ready); end
      for (int k = 0; k < 3; k++) begin
         set_wb(0, 5'd7, 32'(k));
         cyc();
         wb_req = '0; #1;
         n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL sat_ready_after_wb[%0d]: got %b want 1", k, issue_ready); end
         n_tests++; if (pending_any !== (k < 2)) begin n_fail++; $display("FAIL sat_any[%0d]: got %b want %b", k, pending_any, (k < 2)); end
      end
   endtask

   task automatic test_same_cycle();
      do_reset();
      issue_valid = 1'b1; issue_rd = 5'd3;
      cyc();
      rs2_addr = 5'd3;
      set_wb(0, 5'd3, 32'h0000_0033); #1;
      n_tests++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL same_we: got %b want 1", rf_we); end
      cyc();
      issue_valid = 1'b0; wb_req = '0; #1;
      n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL same_stall: got %b want 1", stall); end
      set_wb(0, 5'd3, 32'h0000_0034);
      cyc();
      wb_req = '0; #1;
      n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL same_stall_clear: got %b want 0", stall); end
   endtask

   task automatic test_flush();
      do_reset();
      issue_valid = 1'b1; issue_rd = 5'd4;
      cyc();
      cyc();
      issue_valid = 1'b0; #1;
      n_tests++; if (pending_any !== 1'b1) begin n_fail++; $display("FAIL flush_pre_any: got %b want 1", pending_any); end
      flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd6;
      cyc();
      flush = 1'b0; issue_valid = 1'b0; rs1_addr = 5'd4; #1;
      n_tests++; if (pending_any !== 1'b0) begin n_fail++; $display("FAIL flush_any: got %b want 0", pending_any); end
      n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b want 0", stall); end
      set_wb(1, 5'd4, 32'hF00D_0004); #1;
      n_tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'hF00D_0004)
         begin n_fail++; $display("FAIL flush_late_wb: got we=%b a=%0d d=%h want we=1 a=4 d=f00d0004", rf_we, rf_waddr, rf_wdata); end
      cyc();
      wb_req = '0; #1;
      n_tests++; if (pending_any !== 1'b0) begin n_fail++; $display("FAIL flush_late_any: got %b want 0", pending_any); end
   endtask

   task automatic test_zero_and_async_reset();
      do_reset();
      issue_valid = 1'b1; issue_rd = 5'd0; rs1_addr = 5'd0; #1;
      n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready: got %b want 1", issue_ready); end
      cyc();
      issue_valid = 1'b0;
      set_wb(0, 5'd0, 32'h0000_00AA); #1;
      n_tests++; if (pending_any !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL zero_state: got any=%b stall=%b want 0 0", pending_any, stall); end
      n_tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd0) begin n_fail++; $display("FAIL zero_wb: got we=%b a=%0d want we=1 a=0", rf_we, rf_waddr); end
      cyc();
      wb_req = '0; issue_valid = 1'b1; issue_rd = 5'd9;
      cyc();
      issue_valid = 1'b0; rs1_addr = 5'd9;
      set_wb(1, 5'd9, 32'h0000_0099); #1;
      n_tests++; if (stall !== 1'b1 || rf_we !== 1'b1) begin n_fail++; $display("FAIL pre_rst: got stall=%b we=%b want 1 1", stall, rf_we); end
      #1 rst = 1'b1;
      #1;
      n_tests++; if (stall !== 1'b0 || pending_any !== 1'b0 || issue_ready !== 1'b1)
         begin n_fail++; $display("FAIL async_rst_state: got stall=%b any=%b ready=%b want 0 0 1", stall, pending_any, issue_ready); end
      n_tests++; if (rf_we !== 1'b0 || wb_resp !== 2'b00 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0)
         begin n_fail++; $display("FAIL async_rst_port: got we=%b resp=%b a=%0d d=%h want all 0", rf_we, wb_resp, rf_waddr, rf_wdata); end
      @(negedge clk);
      idle();
      rst = 1'b0;
   endtask

   // Randomized run against an abstract model: an integer count per register and a rotating priority.
   task automatic test_random();
      int          m_pend [32];
      int          m_rr;
      int          g_fix, g_rr, sum;
      logic [4:0]  e_addr;
      logic [31:0] e_data;
      logic [1:0]  e_resp, e_rr_resp;
      logic        e_ready, e_stall, e_any, inc, dec;
      do_reset();
      foreach (m_pend[r]) m_pend[r] = 0;
      m_rr = 0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NWB; i++)
            if (!wb_req[i] && $urandom_range(0, 2) == 0) set_wb(i, 5'($urandom_range(0, 7)), $urandom);
         issue_valid = 1'($urandom_range(0, 1));
         issue_rd    = 5'($urandom_range(0, 7));
         rs1_addr    = 5'($urandom_range(0, 7));
         rs2_addr    = 5'($urandom_range(0, 7));
         flush       = ($urandom_range(0, 29) == 0);
         #1;
         g_fix = -1;
         for (int i = 0; i < NWB; i++) if (g_fix < 0 && wb_req[i]) g_fix = i;
         g_rr = -1;
         for (int k = 0; k < NWB; k++) if (g_rr < 0 && wb_req[(m_rr + k) % NWB]) g_rr = (m_rr + k) % NWB;
         e_addr    = (g_fix >= 0) ? wb_addr[g_fix*AW +: AW] : 5'd0;
         e_data    = (g_fix >= 0) ? wb_data[g_fix*DW +: DW] : 32'd0;
         e_resp    = (g_fix >= 0) ? 2'(1 << g_fix) : 2'b00;
         e_rr_resp = (g_rr >= 0) ? 2'(1 << g_rr) : 2'b00;
         e_ready   = (issue_rd == 0) || (m_pend[issue_rd] < 3);
         e_stall   = (rs1_addr != 0 && m_pend[rs1_addr] > 0) || (rs2_addr != 0 && m_pend[rs2_addr] > 0);
         sum = 0;
         foreach (m_pend[r]) sum += m_pend[r];
         e_any = (sum > 0);
         n_tests++; if (rf_we !== (g_fix >= 0)) begin n_fail++; $display("FAIL rnd_we[%0d]: got %b want %b", c, rf_we, (g_fix >= 0)); end
         n_tests++; if (rf_waddr !== e_addr) begin n_fail++; $display("FAIL rnd_waddr[%0d]: got %0d want %0d", c, rf_waddr, e_addr); end
         n_tests++; if (rf_wdata !== e_data) begin n_fail++; $display("FAIL rnd_wdata[%0d]: got %h want %h", c, rf_wdata, e_data); end
         n_tests++; if (wb_resp !== e_resp) begin n_fail++; $display("FAIL rnd_resp[%0d]: got %b want %b", c, wb_resp, e_resp); end
         n_tests++; if (rr_wb_resp !== e_rr_resp) begin n_fail++; $display("FAIL rnd_rr_resp[%0d]: got %b want %b", c, rr_wb_resp, e_rr_resp); end
         n_tests++; if (issue_ready !== e_ready) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, issue_ready, e_ready); end
         n_tests++; if (stall !== e_stall) begin n_fail++; $display("FAIL rnd_stall[%0d]: got %b want %b", c, stall, e_stall); end
         n_tests++; if (pending_any !== e_any) begin n_fail++; $display("FAIL rnd_any[%0d]: got %b want %b", c, pending_any, e_any); end
         @(posedge clk);
         inc = issue_valid && e_ready && (issue_rd != 0);
         dec = (g_fix >= 0) && (e_addr != 0) && (m_pend[e_addr] > 0);
         if (flush) begin
            foreach (m_pend[r]) m_pend[r] = 0;
         end else begin
            if (inc) m_pend[issue_rd] = m_pend[issue_rd] + 1;
            if (dec) m_pend[e_addr] = m_pend[e_addr] - 1;
         end
         if (g_rr >= 0) m_rr = (g_rr + 1) % NWB;
         @(negedge clk);
         if (g_fix >= 0) wb_req[g_fix] = 1'b0;
      end
      idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_raw();
      test_arbitration();
      test_saturate();
      test_same_cycle();
      test_flush();
      test_zero_and_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
